// File: rtl/rx_ctrl.sv
// Receive-side controller for rx_module: enable sequencing, deferred configuration,
// per-character capture into a first-word-fall-through FIFO, and saturating error counters.
module rx_ctrl #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5,
  parameter int FIFO_AW         = 3,
  parameter int ERR_CNT_W       = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       conf_wr_i,
  input  logic [TOTAL_CONF_W-1:0]    conf_i,
  input  logic                       rd_req_i,
  input  logic                       ovf_clr_i,
  input  logic                       cnt_clr_i,
  input  logic                       rx_done_i,
  input  logic                       rx_busy_i,
  input  logic                       rx_parity_err_i,
  input  logic                       rx_stop_err_i,
  input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
  output logic                       rx_en_o,
  output logic [TOTAL_CONF_W-1:0]    rx_conf_o,
  output logic                       conf_pend_o,
  output logic                       rd_valid_o,
  output logic [MAX_UART_DATA_W-1:0] rd_data_o,
  output logic [1:0]                 rd_err_o,
  output logic [FIFO_AW:0]           fifo_count_o,
  output logic                       overflow_o,
  output logic [ERR_CNT_W-1:0]       parity_cnt_o,
  output logic [ERR_CNT_W-1:0]       stop_cnt_o
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int ENTRY_W = MAX_UART_DATA_W + 2;

  localparam logic [FIFO_AW-1:0] PTR_ONE = 1;
  localparam logic [FIFO_AW:0]   CNT_ONE = 1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = 1;

  state_e                    state_q, state_d;
  logic                      rx_en_q, rx_en_d;
  logic [TOTAL_CONF_W-1:0]   rx_conf_q, rx_conf_d;
  logic [TOTAL_CONF_W-1:0]   shadow_q, shadow_d;
  logic                      pend_q, pend_d;
  logic                      done_q, done_d;
  logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]          count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic [ERR_CNT_W-1:0]      pcnt_q, pcnt_d;
  logic [ERR_CNT_W-1:0]      scnt_q, scnt_d;
  logic [ENTRY_W-1:0]        mem_q [DEPTH];

  logic                       cap;
  logic                       push;
  logic                       pop;
  logic                       wr;
  logic                       empty;
  logic                       full;
  logic                       pend_eff;
  logic [TOTAL_CONF_W-1:0]    shadow_eff;
  logic [MAX_UART_DATA_W-1:0] masked;
  logic [ENTRY_W-1:0]         entry;
  logic [ENTRY_W-1:0]         head;
  int                         data_bits;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:   if (enable_i) state_d = ST_RUN;
      ST_RUN:   if (!enable_i) state_d = rx_busy_i ? ST_DRAIN : ST_OFF;
      ST_DRAIN: begin
        if (enable_i)        state_d = ST_RUN;
        else if (!rx_busy_i) state_d = ST_OFF;
      end
      default:  state_d = ST_OFF;
    endcase
    rx_en_d = (state_d != ST_OFF);
  end

  // One push per character: only the rising edge of the multi-cycle done strobe counts.
  always_comb begin
    done_d    = rx_done_i;
    cap       = rx_done_i & ~done_q;
    push      = cap & (state_q != ST_OFF);
    data_bits = 5 + int'(rx_conf_q[TOTAL_CONF_W-1 -: 2]);
    masked    = '0;
    for (int i = 0; i < MAX_UART_DATA_W; i++) begin
      masked[i] = rx_data_i[i] & (i < data_bits);
    end
    entry = {rx_stop_err_i, rx_parity_err_i, masked};
  end

  // A write landing on the apply cycle is folded in so the newest value wins.
  always_comb begin
    pend_eff   = pend_q | conf_wr_i;
    shadow_eff = conf_wr_i ? conf_i : shadow_q;
    shadow_d   = shadow_eff;
    rx_conf_d  = rx_conf_q;
    pend_d     = pend_eff;
    if (pend_eff && !rx_busy_i && !cap) begin
      rx_conf_d = shadow_eff;
      pend_d    = 1'b0;
    end
  end

  always_comb begin
    empty    = (count_q == '0);
    full     = count_q[FIFO_AW];
    pop      = rd_req_i & ~empty;
    wr       = push & (~full | pop);
    wr_ptr_d = wr  ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (ovf_clr_i)                 ovf_d = 1'b0;
    if (push && full && !pop)      ovf_d = 1'b1;
  end

  // Counters see every accepted capture, including ones the full FIFO drops.
  always_comb begin
    pcnt_d = pcnt_q;
    scnt_d = scnt_q;
    if (cnt_clr_i) begin
      pcnt_d = '0;
      scnt_d = '0;
    end else begin
      if (push && rx_parity_err_i && !(&pcnt_q)) pcnt_d = pcnt_q + ERR_ONE;
      if (push && rx_stop_err_i   && !(&scnt_q)) scnt_d = scnt_q + ERR_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      rx_en_q   <= 1'b0;
      rx_conf_q <= '0;
      shadow_q  <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      pcnt_q    <= '0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      rx_en_q   <= rx_en_d;
      rx_conf_q <= rx_conf_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      pcnt_q    <= pcnt_d;
      scnt_q    <= scnt_d;
    end
  end

  // NOTE: storage is not reset; the reset pointers/count mark it empty and the outputs are gated.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wr_ptr_q] <= entry;
  end

  always_comb begin
    head       = mem_q[rd_ptr_q];
    rd_valid_o = ~empty;
    rd_data_o  = empty ? '0 : head[MAX_UART_DATA_W-1:0];
    rd_err_o   = empty ? '0 : head[ENTRY_W-1 -: 2];
  end

  assign rx_en_o      = rx_en_q;
  assign rx_conf_o    = rx_conf_q;
  assign conf_pend_o  = pend_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = ovf_q;
  assign parity_cnt_o = pcnt_q;
  assign stop_cnt_o   = scnt_q;

endmodule
